// File: rtl/hc_pkg.sv
// ============================================================================
// Module      : hc_pkg
// Description : Shared types for the hc buffer write/read stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hc_pkg;

    localparam int c_buffer_data_width  = 512;
    localparam int c_request_size_width = 32;

    typedef logic [c_buffer_data_width-1:0]  t_buffer_data;
    typedef logic [c_request_size_width-1:0] t_request_size;
    typedef logic [7:0]                      t_buffer_id;

    typedef enum logic [1:0] {
        WR_IDLE     = 2'd0,
        WR_RUN      = 2'd1,
        WR_WAIT_ACK = 2'd2,
        WR_DONE     = 2'd3
    } t_wr_stage_state;

endpackage

`default_nettype wire

// File: rtl/stream_skid_buffer.sv
// ============================================================================
// Module      : stream_skid_buffer
// Description : Two-entry first-in first-out holding buffer with push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buffer #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] r_entry0;
    logic [DATA_WIDTH-1:0] r_entry1;
    logic [1:0]            r_count;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_entry0 <= push_data;
                    end else begin
                        r_entry1 <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_entry0 <= r_entry1;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_entry0 <= push_data;
                    end else begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = r_entry0;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/stream_write_stage.sv
// ============================================================================
// Module      : stream_write_stage
// Description : Skid-buffered line stream to buffer write path, with ack-based finish.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_write_stage
    import hc_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_lines,
    input  logic [7:0]            buffer_id,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_valid,
    output logic [7:0]            wr_buffer_id,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_full,
    input  logic                  wr_ack,
    output logic                  busy,
    output logic                  finish,
    output logic [CNT_WIDTH-1:0]  lines_acked,
    output logic                  ack_err
);

    t_wr_stage_state       r_state;
    t_wr_stage_state       w_state_next;
    logic [CNT_WIDTH-1:0]  r_num_lines;
    t_buffer_id            r_buffer_id;
    logic [CNT_WIDTH-1:0]  r_accepted;
    logic [CNT_WIDTH-1:0]  r_issued;
    logic [CNT_WIDTH-1:0]  r_lines_acked;
    logic                  r_wr_valid;
    t_buffer_id            r_wr_buffer_id;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_ack_err;

    logic                  w_start_ok;
    logic                  w_active;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ack_inc;
    logic                  w_ack_spurious;
    logic [CNT_WIDTH-1:0]  w_acked_next;
    logic [DATA_WIDTH-1:0] w_skid_head;
    logic [1:0]            w_skid_count;

    stream_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head      (w_skid_head),
        .count     (w_skid_count)
    );

    always_comb begin
        w_start_ok     = start && ((r_state == WR_IDLE) || (r_state == WR_DONE));
        w_active       = (r_state == WR_RUN) || (r_state == WR_WAIT_ACK);
        in_ready       = (r_state == WR_RUN) && (w_skid_count < 2'd2) && (r_accepted < r_num_lines);
        w_push         = in_valid && in_ready;
        w_pop          = (r_state == WR_RUN) && (w_skid_count != 2'd0) && !wr_full;
        // An ack is only legitimate while some issued line is still unacknowledged.
        w_ack_inc      = w_active && wr_ack && (r_lines_acked < r_issued) && (r_lines_acked < r_num_lines);
        w_ack_spurious = w_active && wr_ack && (r_lines_acked >= r_issued);
        w_acked_next   = r_lines_acked + {{(CNT_WIDTH-1){1'b0}}, w_ack_inc};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WR_IDLE, WR_DONE: begin
                if (w_start_ok) begin
                    w_state_next = (num_lines == '0) ? WR_DONE : WR_RUN;
                end
            end
            WR_RUN: begin
                if (r_issued == r_num_lines) begin
                    w_state_next = WR_WAIT_ACK;
                end
            end
            WR_WAIT_ACK: begin
                // Looking at the post-ack count lets finish rise the cycle after the last ack.
                if (w_acked_next == r_num_lines) begin
                    w_state_next = WR_DONE;
                end
            end
            default: w_state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_lines    <= '0;
            r_buffer_id    <= '0;
            r_accepted     <= '0;
            r_issued       <= '0;
            r_lines_acked  <= '0;
            r_wr_valid     <= 1'b0;
            r_wr_buffer_id <= '0;
            r_wr_data      <= '0;
            r_ack_err      <= 1'b0;
        end else if (w_start_ok) begin
            r_num_lines   <= num_lines;
            r_buffer_id   <= buffer_id;
            r_accepted    <= '0;
            r_issued      <= '0;
            r_lines_acked <= '0;
            r_wr_valid    <= 1'b0;
            r_ack_err     <= 1'b0;
        end else begin
            r_wr_valid    <= w_pop;
            r_lines_acked <= w_acked_next;
            if (w_push) begin
                r_accepted <= r_accepted + 1'b1;
            end
            if (w_pop) begin
                r_issued       <= r_issued + 1'b1;
                r_wr_data      <= w_skid_head;
                r_wr_buffer_id <= r_buffer_id;
            end
            if (w_ack_spurious) begin
                r_ack_err <= 1'b1;
            end
        end
    end

    assign wr_valid     = r_wr_valid;
    assign wr_buffer_id = r_wr_buffer_id;
    assign wr_data      = r_wr_data;
    assign lines_acked  = r_lines_acked;
    assign ack_err      = r_ack_err;
    assign busy         = w_active;
    assign finish       = (r_state == WR_DONE);

endmodule

`default_nettype wire

// File: tb/tb_stream_write_stage.sv
// ============================================================================
// Module      : tb_stream_write_stage
// Description : Scoreboard and vector-table bench for stream_write_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_write_stage;

    localparam int DW = 512;
    localparam int CW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_lines;
    logic [7:0]    buffer_id;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          wr_valid;
    logic [7:0]    wr_buffer_id;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          wr_ack;
    logic          busy;
    logic          finish;
    logic [CW-1:0] lines_acked;
    logic          ack_err;

    stream_write_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
        .buffer_id(buffer_id), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_valid(wr_valid), .wr_buffer_id(wr_buffer_id),
        .wr_data(wr_data), .wr_full(wr_full), .wr_ack(wr_ack), .busy(busy),
        .finish(finish), .lines_acked(lines_acked), .ack_err(ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned num;
        logic [7:0]  id;
        int          full_lo;
        int          full_hi;
        int          ir_cyc;
        int unsigned exp_writes;
        int unsigned exp_acked;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [DW+7:0] exp_q[$];
    logic [2:0]    ack_pipe;
    logic          extra_ack;
    logic [7:0]    cur_id;
    int unsigned   target, fed, n_wr, acks_sent;
    int            cyc, last_ack_cyc, first_xfer, first_wr, ir_cyc;
    logic          prev_full;

    function automatic logic [DW-1:0] line_of(input int unsigned v);
        return {16{v}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, score what the DUT shows now, then advance.
    task automatic cycle(input bit drive_valid, input bit full);
        logic [DW+7:0] e;
        in_valid = drive_valid && (fed < target);
        in_data  = line_of(fed);
        wr_full  = full;
        wr_ack   = ack_pipe[2] | extra_ack;
        if (wr_ack) begin
            acks_sent++;
            last_ack_cyc = cyc;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back({cur_id, in_data});
            if (first_xfer < 0) first_xfer = cyc;
            fed++;
        end
        if (prev_full) chk("wr_valid_stall", {63'd0, wr_valid}, 64'd0);
        if (ir_cyc == cyc) chk("in_ready_bp", {63'd0, in_ready}, 64'd0);
        if (wr_valid) begin
            if (first_wr < 0) first_wr = cyc;
            n_wr++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got wr_valid=1 expected no write (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (wr_data !== e[DW-1:0]) begin
                    errors++;
                    $display("FAIL wr_data: got %0h expected %0h", wr_data[31:0], e[31:0]);
                end
                chk("wr_buffer_id", {56'd0, wr_buffer_id}, {56'd0, e[DW+7:DW]});
            end
        end
        ack_pipe  = {ack_pipe[1:0], wr_valid};
        prev_full = full;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input int unsigned num, input logic [7:0] id);
        exp_q.delete();
        ack_pipe = '0;
        target = num; fed = 0; n_wr = 0; acks_sent = 0;
        cyc = 0; last_ack_cyc = 0; first_xfer = -1; first_wr = -1;
        prev_full = 1'b0;
        cur_id = id;
        start = 1'b1; num_lines = num; buffer_id = id;
        cycle(1'b0, 1'b0);
        start = 1'b0;
    endtask

    task automatic run_to_finish(input int lo, input int hi, input int budget);
        for (int k = 0; k < budget && !finish; k++) begin
            cycle(1'b1, (cyc >= lo) && (cyc <= hi));
        end
        chk("finish", {63'd0, finish}, 64'd1);
        chk("finish_timing", 64'(cyc), 64'(last_ack_cyc + 1));
    endtask

    vec_t vecs[5];

    initial begin
        reset = 1'b1; start = 1'b0; num_lines = '0; buffer_id = '0;
        in_valid = 1'b0; in_data = '0; wr_full = 1'b0; wr_ack = 1'b0;
        extra_ack = 1'b0; ack_pipe = '0; ir_cyc = -1; cyc = 0; prev_full = 1'b0;
        target = 0; fed = 0;

        vecs[0] = '{num: 30, id: 8'd0,   full_lo: -1, full_hi: -1, ir_cyc: -1, exp_writes: 30, exp_acked: 30};
        vecs[1] = '{num: 8,  id: 8'd0,   full_lo: 5,  full_hi: 15, ir_cyc: 10, exp_writes: 8,  exp_acked: 8};
        vecs[2] = '{num: 0,  id: 8'd7,   full_lo: -1, full_hi: -1, ir_cyc: -1, exp_writes: 0,  exp_acked: 0};
        vecs[3] = '{num: 5,  id: 8'd3,   full_lo: -1, full_hi: -1, ir_cyc: -1, exp_writes: 5,  exp_acked: 5};
        vecs[4] = '{num: 3,  id: 8'hff,  full_lo: 2,  full_hi: 4,  ir_cyc: -1, exp_writes: 3,  exp_acked: 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_finish", {63'd0, finish}, 64'd0);
        chk("rst_lines_acked", 64'(lines_acked), 64'd0);
        chk("rst_ack_err", {63'd0, ack_err}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            ir_cyc = vecs[v].ir_cyc;
            do_start(vecs[v].num, vecs[v].id);
            if (vecs[v].num != 0) begin
                chk("start_clears_finish", {63'd0, finish}, 64'd0);
                chk("start_busy", {63'd0, busy}, 64'd1);
            end else begin
                chk("zero_in_ready", {63'd0, in_ready}, 64'd0);
            end
            run_to_finish(vecs[v].full_lo, vecs[v].full_hi, 400);
            chk("n_writes", 64'(n_wr), 64'(vecs[v].exp_writes));
            chk("lines_acked", 64'(lines_acked), 64'(vecs[v].exp_acked));
            chk("queue_empty", 64'(exp_q.size()), 64'd0);
            if (first_xfer >= 0 && vecs[v].full_lo < 0)
                chk("latency", 64'(first_wr - first_xfer), 64'd2);
            ir_cyc = -1;
        end

        // Spurious ack before anything is issued.
        do_start(2, 8'd1);
        extra_ack = 1'b1;
        cycle(1'b0, 1'b0);
        extra_ack = 1'b0;
        acks_sent = 0;
        chk("spur_ack_err", {63'd0, ack_err}, 64'd1);
        chk("spur_lines_acked", 64'(lines_acked), 64'd0);
        run_to_finish(-1, -1, 200);
        chk("spur_job_acked", 64'(lines_acked), 64'd2);
        chk("spur_ack_err_sticky", {63'd0, ack_err}, 64'd1);
        do_start(1, 8'd1);
        chk("ack_err_cleared", {63'd0, ack_err}, 64'd0);
        run_to_finish(-1, -1, 200);

        // Reset in the middle of a job.
        do_start(30, 8'd9);
        for (int k = 0; k < 200 && n_wr < 10; k++) cycle(1'b1, 1'b0);
        chk("mid_writes", 64'(n_wr), 64'd10);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_valid", {63'd0, wr_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_lines_acked", 64'(lines_acked), 64'd0);
        chk("mid_rst_wr_data", 64'(wr_data[63:0]), 64'd0);
        chk("mid_rst_wr_buffer_id", {56'd0, wr_buffer_id}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_start(4, 8'd2);
        run_to_finish(-1, -1, 200);
        chk("post_rst_writes", 64'(n_wr), 64'd4);
        chk("post_rst_acked", 64'(lines_acked), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_write_stage.md
Name: stream_write_stage

Overview:
- Downstream write stage for the sample accelerators. It sits between a compute/FIFO stage and the write side of hc_buffers_if.
- Accepts a valid/ready 512-bit line stream, holds it in a 2-entry skid buffer, and issues one streaming write request per line to a selected buffer while honouring write-full backpressure.
- Counts write acknowledgements and raises finish once all requested lines are committed. This replaces ad-hoc finish logic in loopback-style tops.

Parameters:
- DATA_WIDTH, 512, line width; must equal the width of t_buffer_data.
- CNT_WIDTH, 32, width of line counters; must equal the width of t_request_size.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a job; honoured only in IDLE or DONE
- num_lines  in  CNT_WIDTH  lines to write; sampled on start
- buffer_id  in  8  destination buffer index; sampled on start
- in_valid  in  1  upstream line valid
- in_ready  out  1  stage can take a line this cycle
- in_data  in  DATA_WIDTH  upstream line
- wr_valid  out  1  write request pulse, one line per cycle
- wr_buffer_id  out  8  destination buffer of the request
- wr_data  out  DATA_WIDTH  line being written
- wr_full  in  1  write path cannot take a request
- wr_ack  in  1  one line committed, one-cycle pulse
- busy  out  1  state is RUN or WAIT_ACK
- finish  out  1  job complete; held high until next start
- lines_acked  out  CNT_WIDTH  acknowledgements received in this job
- ack_err  out  1  sticky flag: an ack arrived while no write was outstanding

Behaviour:
- Reset values:
  - state = IDLE
  - all outputs 0: in_ready, wr_valid, wr_buffer_id, wr_data, busy, finish, lines_acked, ack_err
  - skid count, accepted counter and issued counter cleared
- Reset mid-job aborts immediately; lines still in the skid buffer are dropped.
- States:
  - IDLE: on start, latch num_lines and buffer_id, clear counters, clear finish and ack_err. Go to RUN, or to DONE if num_lines == 0 (finish=1 on the next cycle).
  - RUN: accept and issue lines. When issued == num_lines, go to WAIT_ACK.
  - WAIT_ACK: when lines_acked == num_lines, go to DONE.
  - DONE: finish=1. On start, behave exactly as IDLE does on start.
- start is ignored in RUN and WAIT_ACK.
- Input handshake:
  - in_ready = (state==RUN) && (skid_count<2) && (accepted<num_lines). It depends only on registered state, never combinationally on in_valid or wr_full.
  - A transfer occurs when in_valid && in_ready; the line is pushed at the tail and accepted increments.
- Issue:
  - When skid_count>0 && !wr_full in RUN, next cycle wr_valid=1 with wr_data = head and wr_buffer_id = latched id. The head is popped and issued increments.
  - Otherwise wr_valid=0 on the next cycle. wr_valid is never high for two cycles carrying the same line.
  - Latency from input transfer to wr_valid is 2 cycles when unstalled.
- Simultaneous push and pop keeps skid_count unchanged. Lines leave in arrival order.
- Acks:
  - Each wr_ack increments lines_acked, saturating at num_lines.
  - An ack with lines_acked >= issued sets ack_err and is not counted.
  - An ack in the same cycle as an issue is counted normally.
  - Acks are counted in RUN and WAIT_ACK.
- Counter arithmetic is unsigned CNT_WIDTH with no wrap; num_lines up to 2^CNT_WIDTH-1 must work.

Decomposition:
- hc_pkg: t_buffer_data, t_request_size, a new t_buffer_id (8-bit), and the state enum t_wr_stage_state.
- One natural sub-module: stream_skid_buffer (2-entry, push/pop/count, first-in first-out), reusable on the read side.

Test Plan:
- Basic job: num_lines=30, buffer_id=0, in_valid always 1, wr_full=0, wr_ack 3 cycles after each wr_valid -> 30 wr_valid pulses carrying data 0..29 in order, wr_buffer_id=0, finish rises one cycle after the 30th ack, lines_acked=30.
- Backpressure: num_lines=8, wr_full held high for cycles 5..15 -> wr_valid=0 throughout that window, in_ready drops once 2 lines are buffered, no line lost or duplicated, 8 acks then finish.
- Zero-length job: start with num_lines=0 -> finish=1 the next cycle, no wr_valid, in_ready stays 0.
- Spurious ack: wr_ack with no write outstanding -> ack_err=1, lines_acked unchanged; ack_err clears on the next start.
- Reset mid-job: assert reset after 10 of 30 lines issued -> all outputs 0 at once. A new start with num_lines=4 then completes with finish=1 after 4 acks.
- Restart from DONE: start with num_lines=5, buffer_id=3 while finish=1 -> finish clears, 5 writes go to buffer 3, finish reasserts.
